// File: rtl/turn_lever_conditioner.sv
// Turn-lever conditioner: sync, debounce, arbitrate, hold, gap.
// Optional hazard input and HAZARD state under TURN_HAZARD_EN.
module turn_lever_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HOLD        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
`ifdef TURN_HAZARD_EN
  input  logic hazard_raw,
`endif
  output logic left,
  output logic right,
  output logic busy
);

`ifdef TURN_HAZARD_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
`ifdef TURN_HAZARD_EN
    S_HAZARD,
`endif
    S_GAP
  } state_t;

  typedef enum logic [1:0] {
    P_NONE,
    P_LEFT,
    P_RIGHT
  } pend_t;

  logic [N-1:0]  w_raw;
  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s2;
  logic [N-1:0]  r_d;
  logic [CW-1:0] r_cnt [N];

  state_t        r_state;
  state_t        w_nxt;
  pend_t         r_pend;
  pend_t         w_pend_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic          w_hold_done;
  logic          w_l_only;
  logic          w_r_only;
  logic          w_none;
  logic          w_haz;
  logic          r_left;
  logic          r_right;
  logic          r_busy;

`ifdef TURN_HAZARD_EN
  assign w_raw = {hazard_raw, right_raw, left_raw};
  assign w_haz = r_d[2] | (r_d[0] & r_d[1]);
`else
  assign w_raw = {right_raw, left_raw};
  assign w_haz = 1'b0;
`endif

  assign w_l_only    = r_d[0] & ~r_d[1];
  assign w_r_only    = r_d[1] & ~r_d[0];
  assign w_none      = ~r_d[0] & ~r_d[1];
  assign w_hold_done = (r_hold == HOLD_LAST);

  // Two-flop sync, then accept a level only after a stable run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_d  <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < N; i++) begin
        if (r_s2[i] == r_d[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_d[i]   <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next-state: arbitration, minimum hold, one dead cycle on turn change
  always_comb begin
    w_nxt      = r_state;
    w_pend_nxt = r_pend;
    w_hold_nxt = r_hold;
    unique case (r_state)
      S_IDLE: begin
        if (w_l_only) begin
          w_nxt      = S_LEFT;
          w_hold_nxt = '0;
        end else if (w_r_only) begin
          w_nxt      = S_RIGHT;
          w_hold_nxt = '0;
        end
      end
      S_LEFT: begin
        if (!w_hold_done) begin
          w_hold_nxt = r_hold + 1'b1;
        end else if (w_r_only) begin
          w_nxt      = S_GAP;
          w_pend_nxt = P_RIGHT;
        end else if (w_none) begin
          w_nxt = S_IDLE;
        end
      end
      S_RIGHT: begin
        if (!w_hold_done) begin
          w_hold_nxt = r_hold + 1'b1;
        end else if (w_l_only) begin
          w_nxt      = S_GAP;
          w_pend_nxt = P_LEFT;
        end else if (w_none) begin
          w_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        w_hold_nxt = '0;
        if (r_pend == P_LEFT && w_l_only) begin
          w_nxt = S_LEFT;
        end else if (r_pend == P_RIGHT && w_r_only) begin
          w_nxt = S_RIGHT;
        end else begin
          w_nxt = S_IDLE;
        end
      end
`ifdef TURN_HAZARD_EN
      S_HAZARD: begin
        if (!w_haz) begin
          w_nxt      = S_GAP;
          w_pend_nxt = P_NONE;
        end
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
`ifdef TURN_HAZARD_EN
    if (w_haz) w_nxt = S_HAZARD;
`endif
  end

  // State and outputs registered together from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pend  <= P_NONE;
      r_hold  <= '0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_pend  <= w_pend_nxt;
      r_hold  <= w_hold_nxt;
`ifdef TURN_HAZARD_EN
      r_left  <= (w_nxt == S_LEFT) | (w_nxt == S_HAZARD);
      r_right <= (w_nxt == S_RIGHT) | (w_nxt == S_HAZARD);
`else
      r_left  <= (w_nxt == S_LEFT);
      r_right <= (w_nxt == S_RIGHT);
`endif
      r_busy  <= (w_nxt != S_IDLE);
    end
  end

  assign left  = r_left;
  assign right = r_right;
  assign busy  = r_busy;

endmodule

// File: tb/tb_turn_lever_conditioner.sv
// Bench for turn_lever_conditioner: directed steps plus random levers
// checked against a history-window behavioural model.
module tb_turn_lever_conditioner;

  localparam int D = 4;
  localparam int H = 4;
`ifdef TURN_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left_raw = 1'b0;
  logic right_raw = 1'b0;
  logic hazard_in = 1'b0;
  logic left;
  logic right;
  logic busy;

  int n_chk = 0;
  int n_fail = 0;

  turn_lever_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MIN_HOLD(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .left_raw(left_raw),
    .right_raw(right_raw),
`ifdef TURN_HAZARD_EN
    .hazard_raw(hazard_in),
`endif
    .left(left),
    .right(right),
    .busy(busy)
  );

  always #20 clk = ~clk;

  // model: sync pipeline, history window of synced samples, lamp mode
  bit ms1 [3];
  bit ms2 [3];
  bit md [3];
  bit hist [3][D];
  int nval [3];
  int mdir;
  bit mgap;
  int mpend;
  int mel;
  bit el, er, eb;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rl, input bit rr, input bit rh, input bit rst);
    bit dp [3];
    bit rw [3];
    bit all_diff;
    bit L, R, Hq, own, oth;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        ms1[i] = 0; ms2[i] = 0; md[i] = 0; nval[i] = 0;
        for (int k = 0; k < D; k++) hist[i][k] = 0;
      end
      mdir = 0; mgap = 0; mpend = 0; mel = 0;
    end else begin
      rw[0] = rl; rw[1] = rr; rw[2] = rh;
      for (int i = 0; i < 3; i++) dp[i] = md[i];
      for (int i = 0; i < 3; i++) begin
        for (int k = D - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = ms2[i];
        if (nval[i] < D) nval[i]++;
        all_diff = 1;
        for (int k = 0; k < D; k++) if (hist[i][k] == md[i]) all_diff = 0;
        if (nval[i] >= D && all_diff) begin
          md[i] = ~md[i];
          nval[i] = 0;
        end
        ms2[i] = ms1[i];
        ms1[i] = rw[i];
      end
      L = dp[0]; R = dp[1];
      Hq = HZ && (dp[2] || (L && R));
      if (Hq) begin
        mdir = 3; mgap = 0;
      end else if (mdir == 3) begin
        mdir = 0; mgap = 1; mpend = 0;
      end else if (mgap) begin
        mgap = 0; mdir = 0;
        if (mpend == 1 && L && !R) begin mdir = 1; mel = 0; end
        else if (mpend == 2 && R && !L) begin mdir = 2; mel = 0; end
      end else if (mdir == 0) begin
        if (L && !R) begin mdir = 1; mel = 0; end
        else if (R && !L) begin mdir = 2; mel = 0; end
      end else begin
        own = (mdir == 1) ? L : R;
        oth = (mdir == 1) ? R : L;
        mel++;
        if (mel >= H) begin
          if (!own && oth) begin
            mpend = (mdir == 1) ? 2 : 1;
            mdir = 0; mgap = 1;
          end else if (!own && !oth) begin
            mdir = 0;
          end
        end
      end
    end
    el = (mdir == 1) || (mdir == 3);
    er = (mdir == 2) || (mdir == 3);
    eb = (mdir != 0) || mgap;
  endtask

  // drive 10 ns after an edge, model the edge, check 5 ns after it
  task automatic step(input bit rl, input bit rr, input bit rh, input bit rst);
    left_raw = rl; right_raw = rr; hazard_in = rh; reset = rst;
    @(posedge clk);
    model_edge(rl, rr, rh, rst);
    #5;
    chk("left", int'(left), int'(el));
    chk("right", int'(right), int'(er));
    chk("busy", int'(busy), int'(eb));
    if (!HZ) chk("excl", int'(left & right), 0);
    #5;
  endtask

  initial begin
    int cl, cr, len;
    bit rl, rr, rh;
    #10;
    // 1: latency from a held left lever
    step(0, 0, 0, 1);
    chk("rst_left", int'(left), 0);
    chk("rst_busy", int'(busy), 0);
    for (int k = 1; k <= 7; k++) begin
      step(1, 0, 0, 0);
      if (k == 6) chk("t1_early", int'(left), 0);
    end
    chk("t1_left", int'(left), 1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_right", int'(right), 0);
    // 6: release after long hold, drop on 7th edge
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 0, 0);
      if (k == 6) chk("t6_early", int'(left), 1);
    end
    chk("t6_left", int'(left), 0);
    chk("t6_busy", int'(busy), 0);
    // 2: short glitch ignored
    step(0, 0, 0, 1);
    cl = 0;
    for (int k = 0; k < 3; k++) begin step(1, 0, 0, 0); cl += int'(busy); end
    for (int k = 0; k < 10; k++) begin step(0, 0, 0, 0); cl += int'(busy); end
    chk("t2_busy_cycles", cl, 0);
    // 3: direction change through GAP; right released early is held
    step(0, 0, 0, 1);
    cl = 0; cr = 0;
    for (int k = 1; k <= 4; k++) step(1, 0, 0, 0);
    for (int k = 5; k <= 8; k++) begin
      step(0, 1, 0, 0);
      cl += int'(left);
    end
    for (int k = 9; k <= 20; k++) begin
      step(0, 0, 0, 0);
      cl += int'(left);
      cr += int'(right);
      if (k == 11) chk("t3_gap", int'(left | right), 0);
      if (k == 11) chk("t3_gap_busy", int'(busy), 1);
      if (k == 12) chk("t3_right", int'(right), 1);
    end
    chk("t3_left_cycles", cl, 4);
    chk("t3_right_cycles", cr, 4);
    // 4: both levers together
    step(0, 0, 0, 1);
    for (int k = 1; k <= 15; k++) begin
      step(1, 1, 0, 0);
      if (k == 7) chk("t4_left", int'(left), int'(HZ));
      if (k == 7) chk("t4_right", int'(right), int'(HZ));
    end
    chk("t4_busy", int'(busy), int'(HZ));
    // 5: reset mid-operation, then recovery
    step(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 0);
    chk("t5_pre", int'(right), 1);
    step(0, 1, 0, 1);
    chk("t5_right", int'(right), 0);
    chk("t5_busy", int'(busy), 0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 0, 0);
      if (k == 6) chk("t5_early", int'(right), 0);
    end
    chk("t5_back", int'(right), 1);
    // random lever activity against the model
    for (int seg = 0; seg < 400; seg++) begin
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rh = HZ && ($urandom_range(0, 7) == 0);
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 299) == 0) step(rl, rr, rh, 1);
        else step(rl, rr, rh, 0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
